// File: rtl/alu_muldiv_seq_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
// Contents: MIPS funct codes of the HI/LO group and the sequencer state encoding.
package alu_muldiv_seq_pkg;

   localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
   localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
   localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
   localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
   localparam logic [5:0] FUNCT_MULT  = 6'b011000;
   localparam logic [5:0] FUNCT_MULTU = 6'b011001;
   localparam logic [5:0] FUNCT_DIV   = 6'b011010;
   localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StMul  = 2'd1,
      StDiv  = 2'd2,
      StFix  = 2'd3
   } muldiv_state_e;

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Request/response bundle between the EX-stage ALU datapath and the HI/LO unit.
// master: drives Start_in/Func_in/A_in/B_in, observes results and handshake.
// slave : the HI/LO unit side.
interface alu_muldiv_seq_if #(
   parameter int unsigned WIDTH = 32
);
   logic             Start_in;
   logic [5:0]       Func_in;
   logic [WIDTH-1:0] A_in;
   logic [WIDTH-1:0] B_in;
   logic [WIDTH-1:0] O_out;
   logic [WIDTH-1:0] Hi_out;
   logic [WIDTH-1:0] Lo_out;
   logic             Busy_out;
   logic             Done_out;
   logic             DivZero_out;

   modport master (
      output Start_in, Func_in, A_in, B_in,
      input  O_out, Hi_out, Lo_out, Busy_out, Done_out, DivZero_out
   );

   modport slave (
      input  Start_in, Func_in, A_in, B_in,
      output O_out, Hi_out, Lo_out, Busy_out, Done_out, DivZero_out
   );
endinterface

// File: rtl/muldiv_iter_core.sv
// One-bit-per-clock unsigned shift-add multiplier / restoring divider.
// Ports: i_clk/i_rst (sync, active-high), i_load latches i_a (multiplier or
// dividend, low half) and i_b (multiplicand or divisor) and the mode i_div;
// i_step runs one iteration; o_last is high while the final iteration is due;
// o_hi/o_lo expose the 2*WIDTH shift register (product, or remainder/quotient).
module muldiv_iter_core #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic             i_step,
   input  logic             i_div,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_last,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);
   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_opb;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_div;

   logic [WIDTH:0]     w_mul_sum;
   logic [2*WIDTH-1:0] w_mul_next;
   logic [WIDTH:0]     w_rem_sh;
   logic [WIDTH:0]     w_diff;
   logic [2*WIDTH-1:0] w_div_next;

   // Multiply: add the multiplicand to the upper half when the multiplier LSB
   // is set, then shift the whole register right with the carry.
   assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
   assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

   // Divide: shift left, trial-subtract; a borrow restores the old remainder.
   assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
   assign w_diff     = w_rem_sh - {1'b0, r_opb};
   assign w_div_next = w_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                     : {w_diff[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b1};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_acc <= '0;
         r_opb <= '0;
         r_cnt <= '0;
         r_div <= 1'b0;
      end else if (i_load) begin
         r_acc <= {{WIDTH{1'b0}}, i_a};
         r_opb <= i_b;
         r_cnt <= CNT_W'(WIDTH);
         r_div <= i_div;
      end else if (i_step && (r_cnt != '0)) begin
         r_acc <= r_div ? w_div_next : w_mul_next;
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_last = (r_cnt == CNT_W'(1));
   assign o_hi   = r_acc[2*WIDTH-1:WIDTH];
   assign o_lo   = r_acc[WIDTH-1:0];

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle HI/LO unit: mult, multu, div, divu, mfhi, mflo, mthi, mtlo.
// Ports: Clk_in (rising edge), Reset_in (sync, active-high), io_bus (slave
// modport): Start_in/Func_in/A_in/B_in request; O_out (mfhi/mflo result),
// Hi_out/Lo_out, Busy_out, Done_out (1-cycle pulse), DivZero_out.
// Signed ops iterate on magnitudes; the FIX state restores the signs before
// HI/LO are written, so HI/LO never show intermediate values.
module alu_muldiv_seq
   import alu_muldiv_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input logic                Clk_in,
   input logic                Reset_in,
   alu_muldiv_seq_if.slave    io_bus
);
   muldiv_state_e      r_state;
   logic [WIDTH-1:0]   r_o;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_busy;
   logic               r_done;
   logic               r_dz;
   logic               r_is_mul;
   logic               r_neg_hi;
   logic               r_neg_lo;
   logic               r_fix_wr;
   logic [2*WIDTH-1:0] r_res;

   logic               w_is_mul;
   logic               w_is_div;
   logic               w_signed;
   logic               w_b_zero;
   logic [WIDTH-1:0]   w_abs_a;
   logic [WIDTH-1:0]   w_abs_b;
   logic               w_load;
   logic               w_step;
   logic               w_last;
   logic [WIDTH-1:0]   w_core_hi;
   logic [WIDTH-1:0]   w_core_lo;
   logic [2*WIDTH-1:0] w_fixed;

   assign w_is_mul = (io_bus.Func_in == FUNCT_MULT) || (io_bus.Func_in == FUNCT_MULTU);
   assign w_is_div = (io_bus.Func_in == FUNCT_DIV)  || (io_bus.Func_in == FUNCT_DIVU);
   assign w_signed = (io_bus.Func_in == FUNCT_MULT) || (io_bus.Func_in == FUNCT_DIV);
   assign w_b_zero = (io_bus.B_in == '0);
   assign w_abs_a  = (w_signed && io_bus.A_in[WIDTH-1]) ? -io_bus.A_in : io_bus.A_in;
   assign w_abs_b  = (w_signed && io_bus.B_in[WIDTH-1]) ? -io_bus.B_in : io_bus.B_in;

   assign w_load = (r_state == StIdle) && io_bus.Start_in &&
                   (w_is_mul || (w_is_div && !w_b_zero));
   assign w_step = (r_state == StMul) || (r_state == StDiv);

   muldiv_iter_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .i_clk  (Clk_in),
      .i_rst  (Reset_in),
      .i_load (w_load),
      .i_step (w_step),
      .i_div  (w_is_div),
      .i_a    (w_abs_a),
      .i_b    (w_abs_b),
      .o_last (w_last),
      .o_hi   (w_core_hi),
      .o_lo   (w_core_lo)
   );

   // Product negates as one 2*WIDTH value; quotient and remainder separately.
   always_comb begin
      w_fixed = {w_core_hi, w_core_lo};
      if (r_is_mul) begin
         if (r_neg_lo) w_fixed = -{w_core_hi, w_core_lo};
      end else begin
         if (r_neg_hi) w_fixed[2*WIDTH-1:WIDTH] = -w_core_hi;
         if (r_neg_lo) w_fixed[WIDTH-1:0]       = -w_core_lo;
      end
   end

   always_ff @(posedge Clk_in) begin
      if (Reset_in) begin
         r_state  <= StIdle;
         r_o      <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_dz     <= 1'b0;
         r_is_mul <= 1'b0;
         r_neg_hi <= 1'b0;
         r_neg_lo <= 1'b0;
         r_fix_wr <= 1'b0;
         r_res    <= '0;
      end else begin
         r_done <= 1'b0;
         r_dz   <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (io_bus.Start_in) begin
                  if (w_is_mul) begin
                     r_is_mul <= 1'b1;
                     r_neg_lo <= w_signed && (io_bus.A_in[WIDTH-1] ^ io_bus.B_in[WIDTH-1]);
                     r_neg_hi <= w_signed && (io_bus.A_in[WIDTH-1] ^ io_bus.B_in[WIDTH-1]);
                     r_busy   <= 1'b1;
                     r_state  <= StMul;
                  end else if (w_is_div) begin
                     if (w_b_zero) begin
                        r_done <= 1'b1;
                        r_dz   <= 1'b1;
                     end else begin
                        r_is_mul <= 1'b0;
                        r_neg_lo <= w_signed && (io_bus.A_in[WIDTH-1] ^ io_bus.B_in[WIDTH-1]);
                        r_neg_hi <= w_signed && io_bus.A_in[WIDTH-1];
                        r_busy   <= 1'b1;
                        r_state  <= StDiv;
                     end
                  end else begin
                     unique case (io_bus.Func_in)
                        FUNCT_MFHI: begin r_o  <= r_hi;       r_done <= 1'b1; end
                        FUNCT_MFLO: begin r_o  <= r_lo;       r_done <= 1'b1; end
                        FUNCT_MTHI: begin r_hi <= io_bus.A_in; r_done <= 1'b1; end
                        FUNCT_MTLO: begin r_lo <= io_bus.A_in; r_done <= 1'b1; end
                        default: ;
                     endcase
                  end
               end
            end
            StMul, StDiv: begin
               if (w_last) begin
                  r_state  <= StFix;
                  r_fix_wr <= 1'b0;
               end
            end
            StFix: begin
               // First FIX cycle applies signs, second commits to HI/LO.
               if (!r_fix_wr) begin
                  r_res    <= w_fixed;
                  r_fix_wr <= 1'b1;
               end else begin
                  r_hi     <= r_res[2*WIDTH-1:WIDTH];
                  r_lo     <= r_res[WIDTH-1:0];
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  r_fix_wr <= 1'b0;
                  r_state  <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign io_bus.O_out       = r_o;
   assign io_bus.Hi_out      = r_hi;
   assign io_bus.Lo_out      = r_lo;
   assign io_bus.Busy_out    = r_busy;
   assign io_bus.Done_out    = r_done;
   assign io_bus.DivZero_out = r_dz;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq at WIDTH=32 with hand-computed expectations.
module tb_alu_muldiv_seq;
   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;
   int   n_cyc;
   int   n_seen;

   alu_muldiv_seq_if #(.WIDTH(32)) bus ();

   alu_muldiv_seq #(
      .WIDTH (32)
   ) dut (
      .Clk_in   (clk),
      .Reset_in (rst),
      .io_bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drives one request across a single clock edge (E0).
   task automatic start_op(input logic [5:0] func, input logic [31:0] a, input logic [31:0] b);
      bus.Start_in = 1'b1;
      bus.Func_in  = func;
      bus.A_in     = a;
      bus.B_in     = b;
      tick();
      bus.Start_in = 1'b0;
      bus.Func_in  = 6'b000000;
      bus.A_in     = 32'h0;
      bus.B_in     = 32'h0;
   endtask

   // Continues counting edges until Done_out, bounded at 100.
   task automatic wait_done(inout int n);
      while (!bus.Done_out && n < 100) begin
         tick();
         n++;
      end
   endtask

   initial begin
      n_tests      = 0;
      n_fail       = 0;
      rst          = 1'b1;
      bus.Start_in = 1'b0;
      bus.Func_in  = 6'b000000;
      bus.A_in     = 32'h0;
      bus.B_in     = 32'h0;
      tick();
      tick();
      rst = 1'b0;
      check("rst_o",    bus.O_out,       64'h0);
      check("rst_hi",   bus.Hi_out,      64'h0);
      check("rst_lo",   bus.Lo_out,      64'h0);
      check("rst_busy", bus.Busy_out,    64'h0);
      check("rst_done", bus.Done_out,    64'h0);
      check("rst_dz",   bus.DivZero_out, 64'h0);

      // mult -1 * 2
      start_op(6'b011000, 32'hFFFFFFFF, 32'h00000002);
      check("mult_busy",  bus.Busy_out, 64'h1);
      check("mult_done0", bus.Done_out, 64'h0);
      n_cyc = 0;
      wait_done(n_cyc);
      check("mult_lat",   n_cyc,        64'd34);
      check("mult_hi",    bus.Hi_out,   64'hFFFFFFFF);
      check("mult_lo",    bus.Lo_out,   64'hFFFFFFFE);
      check("mult_busy1", bus.Busy_out, 64'h0);
      tick();
      check("mult_pulse", bus.Done_out, 64'h0);

      // multu 0xFFFFFFFF * 2
      start_op(6'b011001, 32'hFFFFFFFF, 32'h00000002);
      n_cyc = 0;
      wait_done(n_cyc);
      check("multu_hi", bus.Hi_out, 64'h00000001);
      check("multu_lo", bus.Lo_out, 64'hFFFFFFFE);

      // div -7 / 2
      start_op(6'b011010, 32'hFFFFFFF9, 32'h00000002);
      n_cyc = 0;
      wait_done(n_cyc);
      check("div_lat", n_cyc,      64'd34);
      check("div_lo",  bus.Lo_out, 64'hFFFFFFFD);
      check("div_hi",  bus.Hi_out, 64'hFFFFFFFF);

      // divu 100 / 7
      start_op(6'b011011, 32'd100, 32'd7);
      n_cyc = 0;
      wait_done(n_cyc);
      check("divu_lo", bus.Lo_out, 64'd14);
      check("divu_hi", bus.Hi_out, 64'd2);

      // signed overflow case
      start_op(6'b011010, 32'h80000000, 32'hFFFFFFFF);
      n_cyc = 0;
      wait_done(n_cyc);
      check("ovf_lo", bus.Lo_out, 64'h80000000);
      check("ovf_hi", bus.Hi_out, 64'h0);

      // mthi/mtlo then divide by zero
      start_op(6'b010001, 32'h00001234, 32'h0);
      check("mthi_done", bus.Done_out, 64'h1);
      check("mthi_busy", bus.Busy_out, 64'h0);
      start_op(6'b010011, 32'h00005678, 32'h0);
      start_op(6'b011010, 32'h00000009, 32'h0);
      check("dz_done", bus.Done_out,    64'h1);
      check("dz_flag", bus.DivZero_out, 64'h1);
      check("dz_busy", bus.Busy_out,    64'h0);
      check("dz_hi",   bus.Hi_out,      64'h1234);
      check("dz_lo",   bus.Lo_out,      64'h5678);
      tick();
      check("dz_done1", bus.Done_out,    64'h0);
      check("dz_flag1", bus.DivZero_out, 64'h0);

      // mthi then mfhi / mflo
      start_op(6'b010001, 32'hDEADBEEF, 32'h0);
      check("mthi2_o", bus.O_out, 64'h0);
      start_op(6'b010000, 32'h0, 32'h0);
      check("mfhi_o",    bus.O_out,    64'hDEADBEEF);
      check("mfhi_done", bus.Done_out, 64'h1);
      start_op(6'b010010, 32'h0, 32'h0);
      check("mflo_o", bus.O_out, 64'h5678);

      // unknown funct
      tick();
      start_op(6'b100000, 32'h11111111, 32'h22222222);
      check("unk_done", bus.Done_out, 64'h0);
      check("unk_busy", bus.Busy_out, 64'h0);
      check("unk_o",    bus.O_out,    64'h5678);
      check("unk_hi",   bus.Hi_out,   64'hDEADBEEF);

      // multu 3*5 with an ignored divu at cycle 10
      start_op(6'b011001, 32'd3, 32'd5);
      n_cyc = 0;
      repeat (9) begin
         tick();
         n_cyc++;
      end
      start_op(6'b011011, 32'd100, 32'd7);
      n_cyc++;
      check("ign_busy", bus.Busy_out, 64'h1);
      wait_done(n_cyc);
      check("ign_lat", n_cyc,      64'd34);
      check("ign_hi",  bus.Hi_out, 64'h0);
      check("ign_lo",  bus.Lo_out, 64'd15);
      // back-to-back divu on the Done_out cycle
      start_op(6'b011011, 32'd100, 32'd7);
      check("b2b_busy", bus.Busy_out, 64'h1);
      n_cyc = 0;
      wait_done(n_cyc);
      check("b2b_lat", n_cyc,      64'd34);
      check("b2b_lo",  bus.Lo_out, 64'd14);
      check("b2b_hi",  bus.Hi_out, 64'd2);

      // reset mid-mult
      start_op(6'b011000, 32'hFFFFFFFF, 32'h00000002);
      repeat (19) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mrst_o",    bus.O_out,       64'h0);
      check("mrst_hi",   bus.Hi_out,      64'h0);
      check("mrst_lo",   bus.Lo_out,      64'h0);
      check("mrst_busy", bus.Busy_out,    64'h0);
      check("mrst_done", bus.Done_out,    64'h0);
      check("mrst_dz",   bus.DivZero_out, 64'h0);
      n_seen = 0;
      repeat (40) begin
         tick();
         if (bus.Done_out) n_seen++;
      end
      check("mrst_nodone", n_seen, 64'd0);
      start_op(6'b011000, 32'd6, 32'd7);
      n_cyc = 0;
      wait_done(n_cyc);
      check("m67_lat", n_cyc,      64'd34);
      check("m67_lo",  bus.Lo_out, 64'd42);
      check("m67_hi",  bus.Hi_out, 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
